// File: rtl/jellyvl_etherneco_packet_tx.sv
// EtherNeco ring frame transmitter: preamble, SFD, 4-byte header, streamed
// payload and reflected CRC-32 FCS, serialised onto a ready/valid byte stream.
module jellyvl_etherneco_packet_tx #(
  parameter int unsigned GAP_CYCLES   = 12,
  parameter int unsigned PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [7:0]  cmd_type,
  input  logic [7:0]  cmd_node,
  input  logic [15:0] cmd_length,
  output logic        cmd_ready,
  output logic        busy,
  input  logic [7:0]  s_payload_data,
  input  logic        s_payload_valid,
  output logic        s_payload_ready,
  output logic        m_tx_first,
  output logic        m_tx_last,
  output logic [7:0]  m_tx_data,
  output logic        m_tx_valid,
  input  logic        m_tx_ready
);

  localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0]       PRE_LAST = 4'(PREAMBLE_LEN - 1);

  // Each state names the class of byte loaded next into the output register.
  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_HEADER, ST_PAYLOAD, ST_FCS, ST_GAP
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [15:0]      pay_cnt, pay_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [7:0]       lat_type, lat_type_n;
  logic [7:0]       lat_node, lat_node_n;
  logic [15:0]      lat_len, lat_len_n;
  logic [31:0]      crc, crc_n;
  logic             valid_n, first_n, last_n;
  logic [7:0]       data_n;
  logic             can_load;
  logic [7:0]       hdr_byte;
  logic [7:0]       fcs_byte;
  logic [31:0]      fcs;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0000_0000);
    end
    return r;
  endfunction

  // Handshake-side status and byte selection for header and FCS fields.
  always_comb begin
    can_load        = !m_tx_valid || m_tx_ready;
    cmd_ready       = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST));
    busy            = (state != ST_IDLE) && !cmd_ready;
    s_payload_ready = (state == ST_PAYLOAD) && can_load;
    fcs             = ~crc;
    hdr_byte        = 8'h00;
    fcs_byte        = 8'h00;
    case (cnt[1:0])
      2'd0: begin hdr_byte = lat_type;      fcs_byte = fcs[7:0];   end
      2'd1: begin hdr_byte = lat_node;      fcs_byte = fcs[15:8];  end
      2'd2: begin hdr_byte = lat_len[7:0];  fcs_byte = fcs[23:16]; end
      default: begin hdr_byte = lat_len[15:8]; fcs_byte = fcs[31:24]; end
    endcase
  end

  // Next-state and output-register logic; a byte is loaded whenever the
  // output register is empty or being drained this cycle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pay_cnt_n  = pay_cnt;
    gap_cnt_n  = gap_cnt;
    lat_type_n = lat_type;
    lat_node_n = lat_node;
    lat_len_n  = lat_len;
    crc_n      = crc;
    valid_n    = m_tx_valid;
    data_n     = m_tx_data;
    first_n    = m_tx_first;
    last_n     = m_tx_last;

    if (m_tx_valid && m_tx_ready) begin
      valid_n = 1'b0;
      first_n = 1'b0;
      last_n  = 1'b0;
    end

    case (state)
      ST_PREAMBLE: if (can_load) begin
        valid_n = 1'b1;
        data_n  = 8'h55;
        cnt_n   = cnt + 4'd1;
        if (cnt == PRE_LAST) state_n = ST_SFD;
      end
      ST_SFD: if (can_load) begin
        valid_n = 1'b1;
        data_n  = 8'hD5;
        cnt_n   = '0;
        state_n = ST_HEADER;
      end
      ST_HEADER: if (can_load) begin
        valid_n = 1'b1;
        data_n  = hdr_byte;
        crc_n   = crc_next(crc, hdr_byte);
        cnt_n   = cnt + 4'd1;
        if (cnt == 4'd3) begin
          state_n   = ST_PAYLOAD;
          pay_cnt_n = '0;
        end
      end
      ST_PAYLOAD: if (s_payload_valid && s_payload_ready) begin
        valid_n = 1'b1;
        data_n  = s_payload_data;
        crc_n   = crc_next(crc, s_payload_data);
        if (pay_cnt == lat_len) begin
          state_n = ST_FCS;
          cnt_n   = '0;
        end else begin
          pay_cnt_n = pay_cnt + 16'd1;
        end
      end
      ST_FCS: begin
        // cnt==4: all FCS bytes loaded, waiting for the final handshake.
        if (cnt == 4'd4) begin
          if (m_tx_valid && m_tx_ready) begin
            state_n   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            gap_cnt_n = '0;
          end
        end else if (can_load) begin
          valid_n = 1'b1;
          data_n  = fcs_byte;
          last_n  = (cnt == 4'd3);
          cnt_n   = cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = ST_IDLE;
        else                     gap_cnt_n = gap_cnt + 1'b1;
      end
      default: ;
    endcase

    // Acceptance overrides IDLE/final-GAP handling; output register is empty here.
    if (cmd_start && cmd_ready) begin
      lat_type_n = cmd_type;
      lat_node_n = cmd_node;
      lat_len_n  = cmd_length;
      crc_n      = '1;
      valid_n    = 1'b1;
      data_n     = 8'h55;
      first_n    = 1'b1;
      last_n     = 1'b0;
      cnt_n      = 4'd1;
      state_n    = (PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
    end
  end

  // State and output register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pay_cnt    <= '0;
      gap_cnt    <= '0;
      lat_type   <= '0;
      lat_node   <= '0;
      lat_len    <= '0;
      crc        <= '1;
      m_tx_valid <= 1'b0;
      m_tx_data  <= '0;
      m_tx_first <= 1'b0;
      m_tx_last  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pay_cnt    <= pay_cnt_n;
      gap_cnt    <= gap_cnt_n;
      lat_type   <= lat_type_n;
      lat_node   <= lat_node_n;
      lat_len    <= lat_len_n;
      crc        <= crc_n;
      m_tx_valid <= valid_n;
      m_tx_data  <= data_n;
      m_tx_first <= first_n;
      m_tx_last  <= last_n;
    end
  end

endmodule

// File: doc/jellyvl_etherneco_packet_tx.md
# jellyvl_etherneco_packet_tx

Packet transmitter for the EtherNeco ring. It is the transmit-side counterpart of the ring packet receiver. A command port requests a frame; the block then serialises preamble, SFD, header, a payload pulled from a streaming source, and an Ethernet CRC-32 FCS onto a byte stream with ready/valid handshake. The master node uses it to originate ring frames, which slave nodes then parse, rewrite and forward.

## Interface
Parameters:
- GAP_CYCLES, 12, idle cycles forced after the last FCS byte before the next frame may start (0 allowed)
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..15)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- cmd_start  input  1  frame request, sampled when cmd_ready=1
- cmd_type  input  8  header type byte
- cmd_node  input  8  header node byte
- cmd_length  input  16  payload byte count minus one
- cmd_ready  output  1  idle and gap elapsed; request accepted this cycle if cmd_start=1
- busy  output  1  frame in progress or gap running
- s_payload_data  input  8  payload byte
- s_payload_valid  input  1  payload byte valid
- s_payload_ready  output  1  payload byte consumed
- m_tx_first  output  1  first byte of frame (first preamble byte)
- m_tx_last  output  1  last byte of frame (FCS byte 3)
- m_tx_data  output  8  frame byte
- m_tx_valid  output  1  output byte valid
- m_tx_ready  input  1  downstream accepts byte

## Operation
- Frame byte order: PREAMBLE_LEN × 0x55, 0xD5, type, node, length[7:0], length[15:8], payload (cmd_length+1 bytes), FCS[7:0], FCS[15:8], FCS[23:16], FCS[31:24].
- FCS: reflected CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. It covers the type byte through the last payload byte and excludes preamble/SFD.
- States: IDLE → PREAMBLE → SFD → HEADER (4 bytes) → PAYLOAD → FCS (4 bytes) → GAP → IDLE. GAP is skipped when GAP_CYCLES=0.
- cmd_type/node/length are latched on acceptance. Later changes to the inputs do not affect the frame in flight.
- A byte counter advances only on an output handshake (m_tx_valid & m_tx_ready). The payload counter is 16 bits and compared to the latched length; length 0xFFFF yields 65536 bytes with no wrap error.
- PAYLOAD is pass-through with an output register: s_payload_ready=1 only in PAYLOAD when the output register is empty or being drained this cycle. A byte is loaded on s_payload_valid & s_payload_ready.
- Payload underrun (s_payload_valid=0): m_tx_valid drops, the frame stalls and the CRC holds. No error is generated.
- s_payload_ready=0 in every state except PAYLOAD. Extra source bytes wait for the next frame.
- cmd_start while cmd_ready=0 is ignored. It is not queued.

## Timing
- Reset values: m_tx_valid=0, m_tx_first=0, m_tx_last=0, m_tx_data=0x00, s_payload_ready=0, cmd_ready=1, busy=0, state IDLE, CRC register 0xFFFFFFFF.
- Reset asserted mid-frame: all outputs return to their reset values immediately, with no truncation marker. After release the block is in IDLE with cmd_ready=1.
- Acceptance in cycle t: cmd_ready=0 and busy=1 from t+1, and m_tx_valid=1 with data 0x55 and first=1 at t+1.
- While m_tx_valid=1 and m_tx_ready=0, data/first/last are held stable. m_tx_valid never deasserts without a handshake.
- Minimum frame time with m_tx_ready=1 and the payload always valid: PREAMBLE_LEN+1+4+(L+1)+4 cycles, one byte per cycle with no bubbles. The PAYLOAD→FCS transition also has no bubble.
- GAP counting starts on the cycle after the handshake of the FCS byte 3. cmd_ready returns to 1 exactly GAP_CYCLES cycles later. With GAP_CYCLES=0, a new request is accepted on the cycle after the last handshake.
- cmd_start on the same cycle cmd_ready rises is accepted.

## Test plan
- Basic frame: type=0x10, node=0x03, length=0x0003, payload 0x01..0x04, ready=1 → 20 bytes: 7×0x55, 0xD5, 0x10, 0x03, 0x03, 0x00, 0x01..0x04, then 4 FCS bytes; first on byte 0 only, last on byte 19 only. A CRC run over type..FCS (no final XOR) yields residue 0xDEBB20E3.
- Backpressure: same frame, m_tx_ready random at 30% → identical byte sequence, outputs stable while stalled, no dropped or duplicated bytes.
- Underrun: s_payload_valid low for 5 cycles mid-payload → m_tx_valid=0 for those cycles; the FCS is unchanged from the basic-frame value.
- Single-byte payload, length=0x0000, payload 0xAA → 17-byte frame; s_payload_ready high for exactly one handshake.
- Gap and ignore: GAP_CYCLES=12, cmd_start held high continuously → the second frame's first byte comes 13 cycles after the first frame's last handshake (cmd_ready back at +12, accepted, first byte at +13); requests during the frame are ignored.
- Async reset: drive reset=0 during payload byte 2 → m_tx_valid=0 and cmd_ready=1 without waiting for a clock edge; after release, a new frame is bit-identical to the basic-frame result.
